// File: rtl/modbus_frame_rx_ctrl_if.sv
// rtl/modbus_frame_rx_ctrl_if.sv - receiver, frame-buffer and PDU handshake bundle for the Modbus RTU frame controller
//
// Purpose: groups the signals between the UART receiver, the frame buffer write
// port and the PDU decoder. The frame controller uses the master modport, and its
// environment uses the slave modport.
// Signals:
//   rx_data/rx_done/rx_state : byte, one-cycle done pulse and busy flag from the UART receiver
//   wr_en/wr_addr/wr_data    : frame buffer write port
//   frame_valid/frame_len/frame_err/frame_ack : completed-frame handshake to the PDU decoder
//   busy                     : controller is inside a frame (RECV or WAIT_END)
interface modbus_frame_rx_ctrl_if #(
    parameter int ADDR_W = 8
);
    logic [7:0]        rx_data;
    logic              rx_done;
    logic              rx_state;
    logic              wr_en;
    logic [ADDR_W-1:0] wr_addr;
    logic [7:0]        wr_data;
    logic              frame_valid;
    logic [ADDR_W:0]   frame_len;
    logic [1:0]        frame_err;
    logic              frame_ack;
    logic              busy;

    modport master (
        input  rx_data, rx_done, rx_state, frame_ack,
        output wr_en, wr_addr, wr_data, frame_valid, frame_len, frame_err, busy
    );

    modport slave (
        output rx_data, rx_done, rx_state, frame_ack,
        input  wr_en, wr_addr, wr_data, frame_valid, frame_len, frame_err, busy
    );
endinterface

// File: rtl/modbus_frame_rx_ctrl.sv
// rtl/modbus_frame_rx_ctrl.sv - Modbus RTU frame delimiter between the UART receiver and the PDU decoder
//
// Purpose: times inter-character silence against t1.5 and t3.5, writes each
// received byte of a frame into the frame buffer and presents the completed frame
// (length + error flags) with a valid/ack handshake.
// Ports:
//   clk_in   : system clock
//   rst_n_in : asynchronous active-low reset
//   bus      : modbus_frame_rx_ctrl_if.master (receiver inputs, buffer write port,
//              frame handshake, busy)
// frame_err bit0 = inter-character gap between t1.5 and t3.5, bit1 = more than MAX_LEN bytes.
module modbus_frame_rx_ctrl #(
    parameter int CLK_FREQ  = 50000000,
    parameter int BAUD_RATE = 9600,
    parameter int CHAR_BITS = 10,
    parameter int MAX_LEN   = 256,
    parameter int ADDR_W    = 8
) (
    input  logic                         clk_in,
    input  logic                         rst_n_in,
    modbus_frame_rx_ctrl_if.master       bus
);

    localparam int BIT_CLKS = CLK_FREQ / BAUD_RATE;
    localparam int T15_INT  = BIT_CLKS * CHAR_BITS * 3 / 2;
    localparam int T35_INT  = BIT_CLKS * CHAR_BITS * 7 / 2;

    localparam logic [23:0]     T15_CLKS = 24'(T15_INT);
    localparam logic [23:0]     T35_CLKS = 24'(T35_INT);
    localparam logic [ADDR_W:0] MAX_CNT  = (ADDR_W+1)'(MAX_LEN);

    typedef enum logic [2:0] {
        IDLE_WAIT,
        IDLE,
        RECV,
        WAIT_END,
        HOLD
    } state_t;

    state_t            state_q, state_d;
    logic [23:0]       gap_q, gap_d;
    logic [ADDR_W:0]   count_q, count_d;
    logic              dropped_q, dropped_d;
    logic              wr_en_q, wr_en_d;
    logic [ADDR_W-1:0] wr_addr_q, wr_addr_d;
    logic [7:0]        wr_data_q, wr_data_d;
    logic              valid_q, valid_d;
    logic [ADDR_W:0]   len_q, len_d;
    logic [1:0]        err_q, err_d;
    logic              accept;

    always_ff @(posedge clk_in or negedge rst_n_in) begin
        if (!rst_n_in) begin
            state_q   <= IDLE_WAIT;
            gap_q     <= '0;
            count_q   <= '0;
            dropped_q <= 1'b0;
            wr_en_q   <= 1'b0;
            wr_addr_q <= '0;
            wr_data_q <= '0;
            valid_q   <= 1'b0;
            len_q     <= '0;
            err_q     <= '0;
        end else begin
            state_q   <= state_d;
            gap_q     <= gap_d;
            count_q   <= count_d;
            dropped_q <= dropped_d;
            wr_en_q   <= wr_en_d;
            wr_addr_q <= wr_addr_d;
            wr_data_q <= wr_data_d;
            valid_q   <= valid_d;
            len_q     <= len_d;
            err_q     <= err_d;
        end
    end

    always_comb begin
        state_d   = state_q;
        count_d   = count_q;
        dropped_d = dropped_q;
        wr_en_d   = 1'b0;
        wr_addr_d = wr_addr_q;
        wr_data_d = wr_data_q;
        valid_d   = valid_q;
        len_d     = len_q;
        err_d     = err_q;
        accept    = 1'b0;

        // Silence timer: any line activity (even a start bit that never completes)
        // restarts it, so a false start cannot shorten the measured gap.
        if (bus.rx_done || bus.rx_state) begin
            gap_d = '0;
        end else if (gap_q != T35_CLKS) begin
            gap_d = gap_q + 24'd1;
        end else begin
            gap_d = gap_q;
        end

        case (state_q)
            IDLE_WAIT: begin
                // Bytes seen here belong to a frame we joined mid-way; never written.
                if (gap_q == T35_CLKS) begin
                    state_d = IDLE;
                end
            end
            IDLE: begin
                if (bus.rx_done) begin
                    accept  = 1'b1;
                    err_d   = 2'b00;
                    state_d = RECV;
                end
            end
            RECV: begin
                if (bus.rx_done) begin
                    accept = 1'b1;
                end else if (gap_q == T15_CLKS) begin
                    state_d = WAIT_END;
                end
            end
            WAIT_END: begin
                if (bus.rx_done) begin
                    accept   = 1'b1;
                    err_d[0] = 1'b1;
                    state_d  = RECV;
                end else if (gap_q == T35_CLKS) begin
                    valid_d = 1'b1;
                    len_d   = count_q;
                    state_d = HOLD;
                end
            end
            HOLD: begin
                if (bus.rx_done) begin
                    dropped_d = 1'b1;
                end
                if (bus.frame_ack) begin
                    valid_d   = 1'b0;
                    count_d   = '0;
                    dropped_d = 1'b0;
                    // A dropped byte means the line is mid-frame: resynchronise.
                    state_d   = (dropped_q || bus.rx_done) ? IDLE_WAIT : IDLE;
                end
            end
            default: begin
                state_d = IDLE_WAIT;
            end
        endcase

        // Shared byte-write path; count stops at MAX_LEN and extra bytes only flag overflow.
        if (accept) begin
            if (count_q == MAX_CNT) begin
                err_d[1] = 1'b1;
            end else begin
                wr_en_d   = 1'b1;
                wr_addr_d = count_q[ADDR_W-1:0];
                wr_data_d = bus.rx_data;
                count_d   = count_q + 1'b1;
            end
        end
    end

    assign bus.wr_en       = wr_en_q;
    assign bus.wr_addr     = wr_addr_q;
    assign bus.wr_data     = wr_data_q;
    assign bus.frame_valid = valid_q;
    assign bus.frame_len   = len_q;
    assign bus.frame_err   = err_q;
    assign bus.busy        = (state_q == RECV) || (state_q == WAIT_END);

endmodule

// File: tb/tb_modbus_frame_rx_ctrl.sv
// tb/tb_modbus_frame_rx_ctrl.sv - directed self-checking bench for modbus_frame_rx_ctrl
module tb_modbus_frame_rx_ctrl;

    localparam int ADDR_W = 8;

    logic clk_in   = 1'b0;
    logic rst_n_in = 1'b0;

    modbus_frame_rx_ctrl_if #(.ADDR_W(ADDR_W)) bus ();

    modbus_frame_rx_ctrl #(
        .CLK_FREQ (1600000),
        .BAUD_RATE(100000),
        .CHAR_BITS(10),
        .MAX_LEN  (4),
        .ADDR_W   (ADDR_W)
    ) dut (
        .clk_in  (clk_in),
        .rst_n_in(rst_n_in),
        .bus     (bus.master)
    );

    always #5 clk_in = ~clk_in;

    int total = 0;
    int bad   = 0;
    int cyc   = 0;
    int valid_rises = 0;
    int rise_cyc = 0;
    int done_edge = 0;
    logic prev_valid = 1'b0;
    logic [7:0] wq_a[$];
    logic [7:0] wq_d[$];

    always @(posedge clk_in) cyc++;

    // Observe outputs 1 time unit after each active edge.
    always @(posedge clk_in) begin
        #1;
        if (bus.wr_en) begin
            wq_a.push_back(bus.wr_addr);
            wq_d.push_back(bus.wr_data);
        end
        if (bus.frame_valid && !prev_valid) begin
            valid_rises++;
            rise_cyc = cyc;
        end
        prev_valid = bus.frame_valid;
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic idle(input int n);
        repeat (n) @(negedge clk_in);
    endtask

    // One character: 4 cycles of receiver busy, then the done pulse.
    task automatic send_byte(input logic [7:0] d);
        @(negedge clk_in);
        bus.rx_state = 1'b1;
        idle(3);
        @(negedge clk_in);
        bus.rx_state = 1'b0;
        bus.rx_data  = d;
        bus.rx_done  = 1'b1;
        done_edge    = cyc + 1;
        @(negedge clk_in);
        bus.rx_done  = 1'b0;
    endtask

    task automatic wait_valid();
        int n;
        n = 0;
        while (!bus.frame_valid && n < 2000) begin
            @(negedge clk_in);
            n++;
        end
        chk("valid_seen", 32'(bus.frame_valid), 32'd1);
    endtask

    task automatic ack();
        @(negedge clk_in);
        bus.frame_ack = 1'b1;
        @(negedge clk_in);
        bus.frame_ack = 1'b0;
        chk("valid_drop_after_ack", 32'(bus.frame_valid), 32'd0);
    endtask

    initial begin
        bus.rx_data   = 8'h00;
        bus.rx_done   = 1'b0;
        bus.rx_state  = 1'b0;
        bus.frame_ack = 1'b0;
        idle(3);
        chk("rst_wr_en", 32'(bus.wr_en), 32'd0);
        chk("rst_valid", 32'(bus.frame_valid), 32'd0);
        chk("rst_len", 32'(bus.frame_len), 32'd0);
        chk("rst_err", 32'(bus.frame_err), 32'd0);
        chk("rst_busy", 32'(bus.busy), 32'd0);
        rst_n_in = 1'b1;

        // Startup silence then a 3-byte frame.
        idle(600);
        wq_a.delete(); wq_d.delete();
        send_byte(8'h01);
        chk("t1_busy", 32'(bus.busy), 32'd1);
        send_byte(8'h03);
        send_byte(8'h00);
        wait_valid();
        chk("t1_rise_latency", 32'(rise_cyc - done_edge), 32'd561);
        chk("t1_nwrites", 32'(wq_a.size()), 32'd3);
        if (wq_a.size() == 3) begin
            chk("t1_a0", 32'(wq_a[0]), 32'h0); chk("t1_d0", 32'(wq_d[0]), 32'h01);
            chk("t1_a1", 32'(wq_a[1]), 32'h1); chk("t1_d1", 32'(wq_d[1]), 32'h03);
            chk("t1_a2", 32'(wq_a[2]), 32'h2); chk("t1_d2", 32'(wq_d[2]), 32'h00);
        end
        chk("t1_len", 32'(bus.frame_len), 32'd3);
        chk("t1_err", 32'(bus.frame_err), 32'd0);
        chk("t1_busy_hold", 32'(bus.busy), 32'd0);
        idle(20);
        chk("t1_valid_held", 32'(bus.frame_valid), 32'd1);
        ack();

        // Gap error: 300 clocks of silence between bytes.
        idle(10);
        wq_a.delete(); wq_d.delete();
        send_byte(8'h11);
        idle(300);
        chk("t2_busy_wait_end", 32'(bus.busy), 32'd1);
        send_byte(8'h22);
        wait_valid();
        chk("t2_nwrites", 32'(wq_a.size()), 32'd2);
        if (wq_a.size() == 2) begin
            chk("t2_a1", 32'(wq_a[1]), 32'h1); chk("t2_d1", 32'(wq_d[1]), 32'h22);
        end
        chk("t2_len", 32'(bus.frame_len), 32'd2);
        chk("t2_err", 32'(bus.frame_err), 32'd1);
        ack();

        // Overflow with MAX_LEN=4: six bytes back to back.
        idle(10);
        wq_a.delete(); wq_d.delete();
        for (int i = 0; i < 6; i++) send_byte(8'hA0 + 8'(i));
        wait_valid();
        chk("t4_nwrites", 32'(wq_a.size()), 32'd4);
        if (wq_a.size() == 4) begin
            chk("t4_a3", 32'(wq_a[3]), 32'h3); chk("t4_d3", 32'(wq_d[3]), 32'hA3);
        end
        chk("t4_len", 32'(bus.frame_len), 32'd4);
        chk("t4_err", 32'(bus.frame_err), 32'd2);
        ack();

        // Byte during HOLD is dropped and forces a resync.
        idle(10);
        wq_a.delete(); wq_d.delete();
        send_byte(8'h33);
        wait_valid();
        send_byte(8'h77);
        chk("t5_drop_nwrites", 32'(wq_a.size()), 32'd1);
        chk("t5_valid_held", 32'(bus.frame_valid), 32'd1);
        chk("t5_len", 32'(bus.frame_len), 32'd1);
        ack();
        send_byte(8'h44);
        idle(300);
        send_byte(8'h46);
        idle(5);
        chk("t5_resync_ignored", 32'(wq_a.size()), 32'd1);
        idle(600);
        send_byte(8'h45);
        chk("t5_after_resync_nwrites", 32'(wq_a.size()), 32'd2);
        if (wq_a.size() == 2) begin
            chk("t5_a", 32'(wq_a[1]), 32'h0); chk("t5_d", 32'(wq_d[1]), 32'h45);
        end
        wait_valid();
        chk("t5_len2", 32'(bus.frame_len), 32'd1);
        chk("t5_err2", 32'(bus.frame_err), 32'd0);

        // rx_done together with frame_ack in HOLD.
        wq_a.delete(); wq_d.delete();
        @(negedge clk_in);
        bus.frame_ack = 1'b1;
        bus.rx_done   = 1'b1;
        bus.rx_data   = 8'h88;
        @(negedge clk_in);
        bus.frame_ack = 1'b0;
        bus.rx_done   = 1'b0;
        chk("t5s_valid", 32'(bus.frame_valid), 32'd0);
        idle(10);
        send_byte(8'h89);
        idle(3);
        chk("t5s_nwrites", 32'(wq_a.size()), 32'd0);

        // Reset in the middle of a frame.
        idle(600);
        wq_a.delete(); wq_d.delete();
        send_byte(8'hA1);
        send_byte(8'hAB);
        chk("t6_pre_wr_en", 32'(bus.wr_en), 32'd1);
        rst_n_in = 1'b0;
        #1;
        chk("t6_wr_en", 32'(bus.wr_en), 32'd0);
        chk("t6_wr_addr", 32'(bus.wr_addr), 32'd0);
        chk("t6_wr_data", 32'(bus.wr_data), 32'd0);
        chk("t6_busy", 32'(bus.busy), 32'd0);
        chk("t6_valid", 32'(bus.frame_valid), 32'd0);
        idle(3);
        rst_n_in = 1'b1;

        // Byte 100 clocks after reset is ignored; no partial frame is reported.
        idle(100);
        wq_a.delete(); wq_d.delete();
        send_byte(8'h55);
        idle(700);
        chk("t3_no_write", 32'(wq_a.size()), 32'd0);
        chk("t3_no_partial_frame", 32'(valid_rises), 32'd5);
        send_byte(8'h66);
        wait_valid();
        chk("t3_nwrites", 32'(wq_a.size()), 32'd1);
        if (wq_a.size() == 1) begin
            chk("t3_a", 32'(wq_a[0]), 32'h0); chk("t3_d", 32'(wq_d[0]), 32'h66);
        end
        chk("t3_len", 32'(bus.frame_len), 32'd1);
        chk("t3_err", 32'(bus.frame_err), 32'd0);
        ack();

        idle(5);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
